data_sram_resp: RTL

- Single-port data memory responder for the CPU data SRAM interface.
- Accepts `data_sram_en`, `data_sram_we`, `data_sram_addr` and `data_sram_wdata` from the execute stage.
- Returns read data with a fixed one-cycle latency to the memory stage.
- Provides byte-lane writes, an optional post-reset clear sequence and an out-of-range address error flag. Serves as the on-chip data RAM and as the bench-side responder for pipeline tests.

---
 rtl/data_sram_resp.sv | 120 ++++++++++++
 1 files changed

// File: rtl/data_sram_resp.sv
// data_sram_resp: single-port 32-bit data RAM for the CPU data SRAM interface.
// One-cycle read latency, per-byte write enables, optional zero-fill after
// reset, and a one-cycle error pulse for requests outside the address window.
module data_sram_resp #(
    parameter int          ADDR_WIDTH     = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        sram_busy,
    output logic        addr_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt_reg;
    logic [ADDR_WIDTH-1:0]   clr_cnt_next;
    logic [31:0]             rdata_reg;
    logic [31:0]             rdata_next;
    logic                    addr_err_reg;
    logic                    addr_err_next;

    logic [ADDR_WIDTH-1:0]   req_idx;
    logic                    in_range;
    logic [3:0]              mem_we;
    logic [ADDR_WIDTH-1:0]   mem_idx;
    logic [31:0]             mem_wdata;
    logic [31:0]             mem_rd;

    // Byte offset bits are never used: the execute stage filters misaligned accesses.
    logic [1:0]              unused_addr_lsbs;
    assign unused_addr_lsbs = data_sram_addr[1:0];

    assign req_idx   = data_sram_addr[ADDR_WIDTH+1:2];
    assign in_range  = (data_sram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign sram_busy = (state_reg == ST_CLEAR);

    assign data_sram_rdata = rdata_reg;
    assign addr_err        = addr_err_reg;

    // One byte-wide array per lane so each write enable maps onto its own RAM column.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH-1];

            // Lane write port, shared between the clear sequence and CPU stores.
            always_ff @(posedge clk) begin
                if (mem_we[gi]) begin
                    lane_mem[mem_idx] <= mem_wdata[8*gi +: 8];
                end
            end

            assign mem_rd[8*gi +: 8] = lane_mem[req_idx];
        end
    endgenerate

    // State, clear counter and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clr_cnt_reg  <= '0;
            rdata_reg    <= 32'h0;
            addr_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            clr_cnt_reg  <= clr_cnt_next;
            rdata_reg    <= rdata_next;
            addr_err_reg <= addr_err_next;
        end
    end

    // Next-state and request decode; requests are dropped entirely while clearing.
    always_comb begin
        state_next    = state_reg;
        clr_cnt_next  = clr_cnt_reg;
        rdata_next    = rdata_reg;
        addr_err_next = 1'b0;
        mem_we        = 4'b0000;
        mem_idx       = req_idx;
        mem_wdata     = data_sram_wdata;

        if (state_reg == ST_CLEAR) begin
            mem_we       = 4'b1111;
            mem_idx      = clr_cnt_reg;
            mem_wdata    = 32'h0;
            clr_cnt_next = clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == {ADDR_WIDTH{1'b1}}) begin
                state_next = ST_READY;
            end
        end else if (data_sram_en) begin
            if (in_range) begin
                if (data_sram_we != 4'b0000) begin
                    mem_we = data_sram_we;
                end else begin
                    rdata_next = mem_rd;
                end
            end else begin
                addr_err_next = 1'b1;
                if (data_sram_we == 4'b0000) begin
                    rdata_next = 32'h0;
                end
            end
        end
    end

endmodule
